// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage RV32 core. It resolves the
// hazards that EX-stage forwarding cannot cover:
//   - load-use stalls (one bubble, the load then forwards from MEM)
//   - taken-branch / jump redirects (two flushed slots)
//   - multi-cycle EX operations (mul/div), occupying EX for MD_LAT cycles
//   - data-memory wait states (whole front end and MEM frozen)
// Controls are combinational from state, cnt and inputs. State, cnt and
// stall_cnt are registers.
//
// Parameters
//   MD_LAT        total EX occupancy of a multi-cycle op, legal 2..255
//
// Ports
//   clk              core clock, rising edge
//   rst_n            asynchronous active-low reset
//   rs1_ID, rs2_ID   source registers of the ID instruction
//   rs1_used_ID,
//   rs2_used_ID      ID instruction really reads rs1 / rs2
//   wr_EX            destination register of the EX instruction
//   we_EX            EX instruction writes the register file
//   mem_read_EX      EX instruction is a load
//   md_start_EX      EX instruction is a multi-cycle op
//   branch_taken_EX  EX redirects the PC
//   mem_wait         data memory not ready, MEM must not advance
//   pc_hold, ifid_hold, idex_hold, exmem_hold    freeze that register
//   ifid_flush                                   load NOP into IF/ID
//   idex_bubble, exmem_bubble, memwb_bubble      load NOP into that register
//   md_busy          multi-cycle op occupying EX
//   md_done          one-cycle pulse, multi-cycle result valid
//   stall_cnt        number of cycles with pc_hold=1 (wraps)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [4:0]  wr_EX,
    input  logic        we_EX,
    input  logic        mem_read_EX,
    input  logic        md_start_EX,
    input  logic        branch_taken_EX,
    input  logic        mem_wait,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        idex_hold,
    output logic        exmem_hold,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        memwb_bubble,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

    // The RUN-state start cycle is the first occupancy cycle and the final
    // cnt==0 cycle is the done cycle, so MD_LAT-2 hold cycles remain.
    localparam logic [7:0] CNT_LOAD = 8'(MD_LAT - 2);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  cnt_r;
    logic [7:0]  cnt_nxt_s;
    logic [31:0] stall_cnt_r;
    logic        load_use_s;

    // One source operand collides with the EX destination.
    function automatic logic src_hazard(
        input logic [4:0] rs,
        input logic       used,
        input logic [4:0] rd
    );
        return used & (rs == rd);
    endfunction

    // x0 is never a real producer, so a load targeting it cannot cause a stall.
    assign load_use_s = mem_read_EX & we_EX & (wr_EX != 5'd0) &
                        (src_hazard(rs1_ID, rs1_used_ID, wr_EX) |
                         src_hazard(rs2_ID, rs2_used_ID, wr_EX));

    assign stall_cnt = stall_cnt_r;

    // State, down-counter and stall-cycle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            cnt_r       <= 8'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (pc_hold) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    // Next-state and next-count logic; mem_wait freezes everything.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (mem_wait) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = cnt_r;
                end else if (md_start_EX) begin
                    state_nxt_s = ST_MD_BUSY;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_MD_BUSY: begin
                if (mem_wait) begin
                    state_nxt_s = ST_MD_BUSY;
                    cnt_nxt_s   = cnt_r;
                end else if (cnt_r != 8'd0) begin
                    state_nxt_s = ST_MD_BUSY;
                    cnt_nxt_s   = cnt_r - 8'd1;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = 8'd0;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // Pipeline control outputs, by priority within each state.
    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_hold    = 1'b0;
        exmem_hold   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_wait) begin
                    // Hazards in EX/ID persist because EX is held; they are
                    // acted on once memory is ready.
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                end else if (md_start_EX) begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    md_busy      = 1'b1;
                end else if (branch_taken_EX) begin
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                end else if (load_use_s) begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idex_bubble  = 1'b1;
                end else begin
                    pc_hold      = 1'b0;
                end
            end
            ST_MD_BUSY: begin
                if (mem_wait) begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_hold   = 1'b1;
                    memwb_bubble = 1'b1;
                    md_busy      = 1'b1;
                end else if (cnt_r != 8'd0) begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    md_busy      = 1'b1;
                end else begin
                    md_done      = 1'b1;
                end
            end
            default: begin
                md_done = 1'b0;
            end
        endcase
    end

endmodule
